// File: rtl/rx78_ioctl_upload.sv
// rx78_ioctl_upload: core-to-host ioctl upload engine for the RX-78 core.
// Serves hps_io read strobes from a synchronous BRAM port so a RAM region
// (battery/cart RAM) can be saved, either at the host's initiative or after
// a core request via save_trig.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | nothing in progress; waits for save_trig or a matching upload
// S_REQ     | upload_req is high for this single cycle
// S_WAIT_UP | waiting for the host to start the upload; timeout running
// S_ACTIVE  | upload open; answering ioctl_rd strobes
// S_FETCH   | BRAM read in flight; ioctl_din loaded when the latency expires
module rx78_ioctl_upload #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned LEN     = 16'h2000,
  parameter int unsigned MEM_LAT = 1,
  parameter logic [7:0]  INDEX   = 8'd1,
  parameter int unsigned TIMEOUT = 24'd5_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              save_trig,
  output logic              upload_req,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [7:0]        ioctl_din,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_q,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT_UP, S_ACTIVE, S_FETCH
  } state_t;

  // Timeout and fetch timers are down-counters; terminal count is zero.
  localparam logic [24:0] LEN_L    = 25'(LEN);
  localparam logic [23:0] TMO_LAST = 24'(TIMEOUT - 1);
  localparam logic [1:0]  LAT_LOAD = 2'(MEM_LAT);

  state_t            state_q;
  logic [23:0]       tmo_q;
  logic [1:0]        lat_q;
  logic              upload_req_q;
  logic [7:0]        din_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_rd_q;
  logic              done_q;
  logic              err_q;

  logic host_match;
  logic in_range;

  // A non-matching index never opens the channel.
  assign host_match = ioctl_upload && (ioctl_index == INDEX);
  assign in_range   = (ioctl_addr < LEN_L);

  // Sequencer: state, timers and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      tmo_q        <= '0;
      lat_q        <= '0;
      upload_req_q <= 1'b0;
      din_q        <= 8'h00;
      mem_addr_q   <= '0;
      mem_rd_q     <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      upload_req_q <= 1'b0;
      mem_rd_q     <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Host-initiated upload takes precedence over a local request.
          if (host_match) begin
            state_q <= S_ACTIVE;
          end else if (save_trig) begin
            state_q      <= S_REQ;
            upload_req_q <= 1'b1;
            err_q        <= 1'b0;
          end
        end
        S_REQ: begin
          state_q <= S_WAIT_UP;
          tmo_q   <= TMO_LAST;
        end
        S_WAIT_UP: begin
          if (host_match) begin
            state_q <= S_ACTIVE;
          end else if (tmo_q == 24'd0) begin
            state_q <= S_IDLE;
            err_q   <= 1'b1;
          end else begin
            tmo_q <= tmo_q - 24'd1;
          end
        end
        S_ACTIVE: begin
          if (!ioctl_upload) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end else if (ioctl_rd) begin
            if (in_range) begin
              mem_addr_q <= ioctl_addr[ADDR_W-1:0];
              mem_rd_q   <= 1'b1;
              lat_q      <= LAT_LOAD;
              state_q    <= S_FETCH;
            end else begin
              din_q <= 8'hFF;
            end
          end
        end
        S_FETCH: begin
          // Abandoning a fetch leaves ioctl_din at its previous byte.
          if (!ioctl_upload) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end else begin
            if (ioctl_rd) err_q <= 1'b1;
            if (lat_q == 2'd0) begin
              din_q   <= mem_q;
              state_q <= S_ACTIVE;
            end else begin
              lat_q <= lat_q - 2'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign upload_req = upload_req_q;
  assign ioctl_din  = din_q;
  assign mem_addr   = mem_addr_q;
  assign mem_rd     = mem_rd_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_rx78_ioctl_upload.sv
// Directed bench for rx78_ioctl_upload with a 1-cycle-latency BRAM model.
module tb_rx78_ioctl_upload;

  logic        clk = 1'b0;
  logic        reset;
  logic        save_trig;
  logic        upload_req;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_q;
  logic        busy;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;
  int n_memrd = 0;
  int n_done = 0;
  int n_req = 0;
  int base_rd, base_done, base_req;

  logic [7:0] mem [0:8191];

  rx78_ioctl_upload #(
    .ADDR_W (16),
    .LEN    (16'h2000),
    .MEM_LAT(1),
    .INDEX  (8'd1),
    .TIMEOUT(100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .save_trig   (save_trig),
    .upload_req  (upload_req),
    .ioctl_upload(ioctl_upload),
    .ioctl_index (ioctl_index),
    .ioctl_rd    (ioctl_rd),
    .ioctl_addr  (ioctl_addr),
    .ioctl_din   (ioctl_din),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_q       (mem_q),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Synchronous BRAM, one cycle of read latency.
  always @(posedge clk) if (mem_rd) mem_q <= mem[mem_addr[12:0]];

  // Pulse counters, sampled at the edge that closes each cycle.
  always @(posedge clk) begin
    if (mem_rd)     n_memrd++;
    if (done)       n_done++;
    if (upload_req) n_req++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // In-range strobe: mem_rd/mem_addr next cycle, ioctl_din at t+3, 4-cycle spacing.
  task automatic host_read(input logic [24:0] a, input logic [7:0] exp, input string tag);
    ioctl_rd = 1'b1; ioctl_addr = a;
    tick();
    ioctl_rd = 1'b0;
    check({tag, "_mem_rd"}, 32'(mem_rd), 32'd1);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'(a[15:0]));
    tick();
    tick();
    check({tag, "_din"}, 32'(ioctl_din), 32'(exp));
    tick();
  endtask

  // Out-of-range strobe: FF one cycle later, no BRAM read.
  task automatic host_read_oor(input logic [24:0] a, input string tag);
    base_rd = n_memrd;
    ioctl_rd = 1'b1; ioctl_addr = a;
    tick();
    ioctl_rd = 1'b0;
    check({tag, "_din"}, 32'(ioctl_din), 32'hFF);
    check({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
    tick();
    tick();
    check({tag, "_rdcnt"}, 32'(n_memrd - base_rd), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'(i * 7 + 3);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    mem[13'h1FFF] = 8'hA5;
    mem_q = 8'h00;
    reset = 1'b1; save_trig = 1'b0; ioctl_upload = 1'b0; ioctl_index = 8'd0;
    ioctl_rd = 1'b0; ioctl_addr = '0;
    tick(); tick();
    reset = 1'b0;
    check("rst_upload_req", 32'(upload_req), 0);
    check("rst_din", 32'(ioctl_din), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_rd", 32'(mem_rd), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);

    // Core-requested save.
    base_req = n_req; base_done = n_done;
    save_trig = 1'b1;
    tick();
    save_trig = 1'b0;
    check("save_req_hi", 32'(upload_req), 1);
    check("save_busy", 32'(busy), 1);
    tick();
    check("save_req_lo", 32'(upload_req), 0);
    check("save_wait_busy", 32'(busy), 1);
    ioctl_upload = 1'b1; ioctl_index = 8'd1;
    tick();
    host_read(25'd0, 8'h11, "save_a0");
    host_read(25'd1, 8'h22, "save_a1");
    host_read(25'd2, 8'h33, "save_a2");
    host_read(25'd3, 8'h44, "save_a3");
    check("save_din_hold", 32'(ioctl_din), 32'h44);
    ioctl_upload = 1'b0;
    tick();
    check("save_done", 32'(done), 1);
    check("save_busy_lo", 32'(busy), 0);
    tick();
    check("save_done_once", 32'(n_done - base_done), 1);
    check("save_req_once", 32'(n_req - base_req), 1);
    check("save_err", 32'(err), 0);

    // Host-initiated upload, range boundary and address aliasing.
    ioctl_upload = 1'b1; ioctl_index = 8'd1;
    tick();
    check("host_busy", 32'(busy), 1);
    check("host_no_req", 32'(upload_req), 0);
    host_read(25'h1FFF, 8'hA5, "host_last");
    host_read_oor(25'h2000, "host_len");
    host_read(25'd2, 8'h33, "host_a2");
    host_read_oor(25'h100_0002, "host_alias");
    ioctl_upload = 1'b0;
    tick();
    check("host_done", 32'(done), 1);
    tick();

    // Index mismatch: nothing happens.
    base_rd = n_memrd; base_done = n_done;
    ioctl_upload = 1'b1; ioctl_index = 8'd2;
    tick();
    for (int k = 0; k < 2; k++) begin
      ioctl_rd = 1'b1; ioctl_addr = 25'(k);
      tick();
      ioctl_rd = 1'b0;
      tick(); tick(); tick();
    end
    check("idx_busy", 32'(busy), 0);
    check("idx_rdcnt", 32'(n_memrd - base_rd), 0);
    check("idx_din", 32'(ioctl_din), 32'hFF);
    ioctl_upload = 1'b0;
    tick(); tick();
    check("idx_no_done", 32'(n_done - base_done), 0);

    // Strobe during FETCH, then upload falls mid-fetch.
    ioctl_upload = 1'b1; ioctl_index = 8'd1;
    tick();
    base_rd = n_memrd;
    ioctl_rd = 1'b1; ioctl_addr = 25'd1;
    tick();
    ioctl_addr = 25'd3;
    tick();
    ioctl_rd = 1'b0;
    check("viol_err", 32'(err), 1);
    tick();
    check("viol_din", 32'(ioctl_din), 32'h22);
    check("viol_rdcnt", 32'(n_memrd - base_rd), 1);
    tick();
    ioctl_rd = 1'b1; ioctl_addr = 25'd0;
    tick();
    ioctl_rd = 1'b0;
    ioctl_upload = 1'b0;
    tick();
    check("abort_done", 32'(done), 1);
    check("abort_busy", 32'(busy), 0);
    check("abort_din", 32'(ioctl_din), 32'h22);
    tick(); tick();
    check("abort_din_hold", 32'(ioctl_din), 32'h22);
    check("abort_err_sticky", 32'(err), 1);

    // Timeout: WAIT_UP entered two cycles after save_trig.
    base_done = n_done;
    save_trig = 1'b1;
    tick();
    save_trig = 1'b0;
    check("tmo_err_clr", 32'(err), 0);
    tick();
    for (int k = 0; k < 99; k++) tick();
    check("tmo_busy_99", 32'(busy), 1);
    check("tmo_err_99", 32'(err), 0);
    tick();
    check("tmo_busy_100", 32'(busy), 0);
    check("tmo_err_100", 32'(err), 1);
    check("tmo_no_done", 32'(n_done - base_done), 0);

    // Fresh request clears err; then reset while a fetch is in flight.
    save_trig = 1'b1;
    tick();
    save_trig = 1'b0;
    check("retry_err_clr", 32'(err), 0);
    tick();
    ioctl_upload = 1'b1; ioctl_index = 8'd1;
    tick();
    ioctl_rd = 1'b1; ioctl_addr = 25'd0;
    tick();
    ioctl_addr = 25'd2;
    tick();
    ioctl_rd = 1'b0;
    tick();
    check("rst_pre_din", 32'(ioctl_din), 32'h11);
    tick();
    base_done = n_done;
    ioctl_rd = 1'b1; ioctl_addr = 25'd3;
    tick();
    ioctl_rd = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0; ioctl_upload = 1'b0;
    check("rstf_din", 32'(ioctl_din), 0);
    check("rstf_mem_addr", 32'(mem_addr), 0);
    check("rstf_mem_rd", 32'(mem_rd), 0);
    check("rstf_busy", 32'(busy), 0);
    check("rstf_err", 32'(err), 0);
    check("rstf_done", 32'(done), 0);
    check("rstf_req", 32'(upload_req), 0);
    tick(); tick();
    check("rstf_no_done", 32'(n_done - base_done), 0);
    check("rstf_idle", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
